// File: rtl/pwm_frame_scheduler_pkg.sv
// Constants and types shared by the frame scheduler and the PWM block so
// both agree on frame length, sample width and mode encodings.
package pwm_pkg;

    localparam int FRAME_BITS   = 10;
    localparam int DATA_W       = 12;
    localparam int UCNT_W       = 16;
    localparam int FETCH_OFFSET = 2;

    typedef enum logic [1:0] {
        MODE_SRC0 = 2'd0,
        MODE_SRC1 = 2'd1,
        MODE_MIX  = 2'd2,
        MODE_RSVD = 2'd3
    } mode_e;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/pwm_frame_scheduler_counter.sv
// Frame timebase: free-running count while running, parked at zero otherwise,
// with the fetch / commit / frame_start strobes decoded from it.
module pwm_frame_counter #(
    parameter int FRAME_BITS = pwm_pkg::FRAME_BITS
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    input  logic en,
    output logic fetch,
    output logic commit,
    output logic frame_start
);
    import pwm_pkg::*;

    localparam int                    FETCH_I  = (1 << FRAME_BITS) - FETCH_OFFSET;
    localparam logic [FRAME_BITS-1:0] FETCH_AT = FETCH_I[FRAME_BITS-1:0];
    localparam logic [FRAME_BITS-1:0] LAST     = '1;
    localparam logic [FRAME_BITS-1:0] ONE      = {{(FRAME_BITS-1){1'b0}}, 1'b1};

    logic [FRAME_BITS-1:0] count_q;
    logic [FRAME_BITS-1:0] count_d;

    // Leaving RUN or sitting in IDLE both park the count at zero.
    always_comb begin
        count_d = '0;
        if (run && en) begin
            count_d = count_q + ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign fetch       = run && (count_q == FETCH_AT);
    assign commit      = run && (count_q == LAST);
    assign frame_start = run && (count_q == '0);

endmodule

// File: rtl/pwm_frame_scheduler.sv
// Fetches one sample per PWM frame from one or both sources and presents it
// to the PWM DataIn aligned to the frame boundary; tracks missed fetches.
module pwm_frame_scheduler #(
    parameter int FRAME_BITS = pwm_pkg::FRAME_BITS,
    parameter int DATA_W     = pwm_pkg::DATA_W,
    parameter int UCNT_W     = pwm_pkg::UCNT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic [1:0]        mode,
    input  logic              clr_status,
    input  logic              src0_valid,
    input  logic [DATA_W-1:0] src0_data,
    output logic              src0_ready,
    input  logic              src1_valid,
    input  logic [DATA_W-1:0] src1_data,
    output logic              src1_ready,
    output logic [DATA_W-1:0] pwm_data,
    output logic              frame_start,
    output logic              underrun,
    output logic [UCNT_W-1:0] underrun_cnt
);
    import pwm_pkg::*;

    state_e                     state_q, state_d;
    logic signed [DATA_W-1:0]   next_sample_q, next_sample_d;
    logic signed [DATA_W-1:0]   pwm_data_q, pwm_data_d;
    logic                       underrun_q, underrun_d;
    logic        [UCNT_W-1:0]   ucnt_q, ucnt_d;

    logic                       run, fetch, commit, fs;
    logic                       need0, need1, have, take, miss;
    logic signed [DATA_W-1:0]   sample_sel;

    // Mean of two samples: one extra bit of headroom, then floor division by 2.
    function automatic logic signed [DATA_W-1:0] avg2(
        input logic signed [DATA_W-1:0] a,
        input logic signed [DATA_W-1:0] b
    );
        logic signed [DATA_W:0] sum;
        sum = $signed({a[DATA_W-1], a}) + $signed({b[DATA_W-1], b});
        return sum[DATA_W:1];
    endfunction

    assign run = (state_q == RUN);

    pwm_frame_counter #(.FRAME_BITS(FRAME_BITS)) u_counter (
        .clk         (clk),
        .rst_n       (rst_n),
        .run         (run),
        .en          (enable),
        .fetch       (fetch),
        .commit      (commit),
        .frame_start (fs)
    );

    always_comb begin
        need0 = (mode != MODE_SRC1);
        need1 = (mode == MODE_SRC1) || (mode == MODE_MIX);
        have  = (!need0 || src0_valid) && (!need1 || src1_valid);
        // A fetch coinciding with enable dropping is abandoned entirely.
        take  = fetch && enable && have;
        miss  = fetch && enable && !have;

        case (mode)
            MODE_SRC1: sample_sel = $signed(src1_data);
            MODE_MIX:  sample_sel = avg2($signed(src0_data), $signed(src1_data));
            default:   sample_sel = $signed(src0_data);
        endcase

        state_d       = enable ? RUN : IDLE;
        next_sample_d = take ? sample_sel : next_sample_q;

        pwm_data_d = pwm_data_q;
        if (!run || !enable) begin
            pwm_data_d = '0;
        end else if (commit) begin
            pwm_data_d = next_sample_q;
        end

        // Clear first so a miss in the same cycle still registers as one.
        underrun_d = underrun_q && !clr_status;
        ucnt_d     = clr_status ? '0 : ucnt_q;
        if (miss) begin
            underrun_d = 1'b1;
            if (ucnt_d != '1) begin
                ucnt_d = ucnt_d + {{(UCNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            next_sample_q <= '0;
            pwm_data_q    <= '0;
            underrun_q    <= 1'b0;
            ucnt_q        <= '0;
        end else begin
            state_q       <= state_d;
            next_sample_q <= next_sample_d;
            pwm_data_q    <= pwm_data_d;
            underrun_q    <= underrun_d;
            ucnt_q        <= ucnt_d;
        end
    end

    assign src0_ready   = take && need0;
    assign src1_ready   = take && need1;
    assign pwm_data     = pwm_data_q;
    assign frame_start  = fs;
    assign underrun     = underrun_q;
    assign underrun_cnt = ucnt_q;

endmodule

// File: tb/tb_pwm_frame_scheduler.sv
// Bench for pwm_frame_scheduler: frame-level vector table, corner-case
// sequences and randomized traffic against a cycle-level reference model.
module tb_pwm_frame_scheduler;

    localparam int FB    = 4;
    localparam int DW    = 12;
    localparam int UW    = 5;
    localparam int FRAME = 1 << FB;
    localparam int UMAX  = (1 << UW) - 1;

    logic          clk = 1'b0;
    logic          rst_n, enable, clr_status;
    logic [1:0]    mode;
    logic          src0_valid, src1_valid;
    logic [DW-1:0] src0_data, src1_data;
    logic          src0_ready, src1_ready, frame_start, underrun;
    logic [DW-1:0] pwm_data;
    logic [UW-1:0] underrun_cnt;

    int checks   = 0;
    int failures = 0;
    int n_r0, n_r1;

    // Reference model state: running flag, position in frame, staged and
    // presented samples (as plain integers), sticky flag and miss count.
    int m_run = 0, m_cnt = 0, m_next = 0, m_pwm = 0, m_uflag = 0, m_ucnt = 0;

    always #5 clk = ~clk;

    pwm_frame_scheduler #(.FRAME_BITS(FB), .DATA_W(DW), .UCNT_W(UW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .mode         (mode),
        .clr_status   (clr_status),
        .src0_valid   (src0_valid),
        .src0_data    (src0_data),
        .src0_ready   (src0_ready),
        .src1_valid   (src1_valid),
        .src1_data    (src1_data),
        .src1_ready   (src1_ready),
        .pwm_data     (pwm_data),
        .frame_start  (frame_start),
        .underrun     (underrun),
        .underrun_cnt (underrun_cnt)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic int avg_floor(input int a, input int b);
        int s;
        s = a + b;
        return (s >= 0) ? s / 2 : -((1 - s) / 2);
    endfunction

    // One clock: compare against the model at the falling edge, then
    // advance the model with the inputs seen at the rising edge.
    task automatic tick();
        int fetch, need0, need1, ok, r0, r1, d0, d1;
        @(negedge clk);
        d0    = int'($signed(src0_data));
        d1    = int'($signed(src1_data));
        fetch = (m_run != 0) && enable && (m_cnt == FRAME - 2);
        need0 = (mode != 2'd1);
        need1 = (mode == 2'd1) || (mode == 2'd2);
        ok    = (!need0 || src0_valid) && (!need1 || src1_valid);
        r0    = fetch && ok && need0;
        r1    = fetch && ok && need1;
        if (src0_ready) n_r0++;
        if (src1_ready) n_r1++;
        chk("src0_ready", int'(src0_ready), r0);
        chk("src1_ready", int'(src1_ready), r1);
        chk("pwm_data", int'($signed(pwm_data)), m_pwm);
        chk("frame_start", int'(frame_start), int'(m_run != 0 && m_cnt == 0));
        chk("underrun", int'(underrun), m_uflag);
        chk("underrun_cnt", int'(underrun_cnt), m_ucnt);
        @(posedge clk);
        if (!rst_n) begin
            m_run = 0; m_cnt = 0; m_next = 0; m_pwm = 0; m_uflag = 0; m_ucnt = 0;
        end else begin
            if (clr_status) begin
                m_uflag = 0;
                m_ucnt  = 0;
            end
            if (m_run != 0 && enable) begin
                if (fetch != 0) begin
                    if (ok != 0) begin
                        if (mode == 2'd2)      m_next = avg_floor(d0, d1);
                        else if (mode == 2'd1) m_next = d1;
                        else                   m_next = d0;
                    end else begin
                        m_uflag = 1;
                        if (m_ucnt < UMAX) m_ucnt++;
                    end
                end
                if (m_cnt == FRAME - 1) m_pwm = m_next;
                m_cnt = (m_cnt + 1) % FRAME;
            end else begin
                m_run = enable ? 1 : 0;
                m_cnt = 0;
                m_pwm = 0;
            end
        end
        #1;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    // Advance to the next frame_start, bounded so a stuck timebase still ends.
    task automatic to_frame(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!frame_start && n < 4 * FRAME);
        chk("frame_start_reached", int'(frame_start), 1);
    endtask

    typedef struct {
        logic [1:0]    mode;
        logic          v0;
        logic [DW-1:0] d0;
        logic          v1;
        logic [DW-1:0] d1;
        logic [DW-1:0] pwm;
        int            r0;
        int            r1;
        int            miss;
    } vec_t;

    vec_t vt[12];

    initial begin
        int n, u0;

        vt[0]  = '{2'd0, 1'b1, 12'h100, 1'b0, 12'h000, 12'h100, 1, 0, 0};
        vt[1]  = '{2'd2, 1'b1, 12'h7FF, 1'b1, 12'h001, 12'h400, 1, 1, 0};
        // -2048 + -1 = -2049; the arithmetic shift floors this to -1025.
        vt[2]  = '{2'd2, 1'b1, 12'h800, 1'b1, 12'hFFF, 12'hBFF, 1, 1, 0};
        vt[3]  = '{2'd0, 1'b1, 12'h055, 1'b0, 12'h000, 12'h055, 1, 0, 0};
        vt[4]  = '{2'd0, 1'b0, 12'h0AA, 1'b1, 12'h111, 12'h055, 0, 0, 1};
        vt[5]  = '{2'd0, 1'b0, 12'h0AA, 1'b1, 12'h111, 12'h055, 0, 0, 1};
        vt[6]  = '{2'd0, 1'b0, 12'h0AA, 1'b1, 12'h111, 12'h055, 0, 0, 1};
        vt[7]  = '{2'd2, 1'b0, 12'h000, 1'b1, 12'h123, 12'h055, 0, 0, 1};
        vt[8]  = '{2'd1, 1'b1, 12'h7FF, 1'b1, 12'h2AA, 12'h2AA, 0, 1, 0};
        vt[9]  = '{2'd3, 1'b1, 12'h0F0, 1'b0, 12'h000, 12'h0F0, 1, 0, 0};
        vt[10] = '{2'd2, 1'b1, 12'h001, 1'b1, 12'h002, 12'h001, 1, 1, 0};
        vt[11] = '{2'd2, 1'b1, 12'hFFF, 1'b1, 12'hFFF, 12'hFFF, 1, 1, 0};

        rst_n = 1'b0; enable = 1'b0; clr_status = 1'b0; mode = 2'd0;
        src0_valid = 1'b0; src0_data = '0; src1_valid = 1'b0; src1_data = '0;
        n_r0 = 0; n_r1 = 0;
        ticks(2);
        chk("reset_pwm", int'(pwm_data), 0);
        chk("reset_frame_start", int'(frame_start), 0);
        chk("reset_underrun", int'(underrun), 0);
        chk("reset_cnt", int'(underrun_cnt), 0);
        chk("reset_ready", int'(src0_ready | src1_ready), 0);

        rst_n = 1'b1;
        ticks(3);
        chk("idle_frame_start", int'(frame_start), 0);
        enable = 1'b1;
        tick();
        chk("first_run_frame_start", int'(frame_start), 1);

        // Frame-level vector table: inputs held for one frame, result seen
        // at the following frame_start.
        for (int i = 0; i < 12; i++) begin
            mode = vt[i].mode;
            src0_valid = vt[i].v0; src0_data = vt[i].d0;
            src1_valid = vt[i].v1; src1_data = vt[i].d1;
            n_r0 = 0; n_r1 = 0;
            u0 = int'(underrun_cnt);
            to_frame(n);
            chk($sformatf("vec%0d_period", i), n, FRAME);
            chk($sformatf("vec%0d_pwm", i), int'(pwm_data), int'(vt[i].pwm));
            chk($sformatf("vec%0d_r0", i), n_r0, vt[i].r0);
            chk($sformatf("vec%0d_r1", i), n_r1, vt[i].r1);
            chk($sformatf("vec%0d_miss", i), int'(underrun_cnt) - u0, vt[i].miss);
            if (i == 6) chk("three_misses_cnt", int'(underrun_cnt), 3);
        end
        chk("underrun_sticky", int'(underrun), 1);
        clr_status = 1'b1;
        tick();
        clr_status = 1'b0;
        chk("clr_flag", int'(underrun), 0);
        chk("clr_cnt", int'(underrun_cnt), 0);

        // Enable dropped exactly on the fetch cycle.
        to_frame(n);
        mode = 2'd0; src0_valid = 1'b1; src0_data = 12'h1AB;
        ticks(FRAME - 2);
        enable = 1'b0;
        #1;
        chk("drop_fetch_ready", int'(src0_ready), 0);
        tick();
        chk("drop_pwm", int'(pwm_data), 0);
        chk("drop_underrun", int'(underrun), 0);
        chk("drop_cnt", int'(underrun_cnt), 0);
        ticks(2);
        enable = 1'b1;
        tick();
        chk("reenable_frame_start", int'(frame_start), 1);

        // clr_status landing on a miss.
        src0_valid = 1'b0;
        to_frame(n);
        chk("pre_clr_miss", int'(underrun_cnt), 1);
        ticks(FRAME - 2);
        clr_status = 1'b1;
        tick();
        clr_status = 1'b0;
        chk("clr_with_miss_flag", int'(underrun), 1);
        chk("clr_with_miss_cnt", int'(underrun_cnt), 1);

        // Saturate the counter while holding 0x321, then reset mid-frame.
        src0_valid = 1'b1; src0_data = 12'h321;
        to_frame(n);
        to_frame(n);
        chk("pwm_321", int'(pwm_data), 12'h321);
        src0_valid = 1'b0;
        for (int f = 0; f < UMAX + 1; f++) to_frame(n);
        chk("cnt_saturated", int'(underrun_cnt), UMAX);
        chk("hold_321", int'(pwm_data), 12'h321);
        ticks(5);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("midreset_pwm", int'(pwm_data), 0);
        chk("midreset_cnt", int'(underrun_cnt), 0);
        chk("midreset_flag", int'(underrun), 0);
        chk("midreset_fs", int'(frame_start), 0);
        chk("midreset_ready", int'(src0_ready | src1_ready), 0);

        // Randomized traffic, every cycle checked against the model.
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 7) == 0) mode = 2'($urandom_range(0, 3));
            src0_valid = ($urandom_range(0, 3) != 0);
            src1_valid = ($urandom_range(0, 3) != 0);
            src0_data  = DW'($urandom);
            src1_data  = DW'($urandom);
            enable     = ($urandom_range(0, 63) != 0);
            clr_status = ($urandom_range(0, 49) == 0);
            rst_n      = ($urandom_range(0, 299) != 0);
            tick();
        end
        rst_n = 1'b1; clr_status = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
